driver_lampada_pwm: RTL and testbench

Soft-start/soft-stop PWM lamp driver. It sits directly downstream of the lamp controller `controladora` and takes that block's `saida` on/off request as `liga`. It ramps the lamp duty cycle up to a programmable brightness level, or down to zero, at a fixed rate. It drives the lamp through a single PWM pin and reports ramp status.

---
 rtl/driver_lampada_pwm_pkg.sv | 19 +
 rtl/driver_lampada_pwm_if.sv | 30 +++
 rtl/driver_lampada_pwm_gerador_pwm.sv | 30 +++
 rtl/driver_lampada_pwm.sv | 89 ++++++++
 tb/tb_driver_lampada_pwm.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/driver_lampada_pwm_pkg.sv
// Shared types for the soft-start / soft-stop PWM lamp driver.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: ramp state enum and a helper that tells whether a state is ramping.
package lampada_pkg;

  typedef enum logic [1:0] {
    REPOUSO  = 2'd0,  // lamp off, duty==0 and target==0
    SUBINDO  = 2'd1,  // ramping up towards target
    ACESA    = 2'd2,  // lamp on, duty==target!=0
    DESCENDO = 2'd3   // ramping down towards target
  } estado_lampada_t;

  function automatic logic em_rampa(input estado_lampada_t e);
    return (e == SUBINDO) || (e == DESCENDO);
  endfunction

endpackage

// File: rtl/driver_lampada_pwm_if.sv
// Lamp request / lamp drive bundle between the controller side and the PWM driver.
// Latency: n/a (wires only).
// Backpressure: none; liga/nivel are level signals sampled every cycle.
//
// Signals: liga (on request), nivel (target brightness), pwm_out (lamp pin),
//          duty (current duty), estavel (no ramp running), ocupado (ramping).
interface driver_lampada_pwm_if #(
  parameter int PWM_BITS = 8
) ();

  logic                liga;
  logic [PWM_BITS-1:0] nivel;
  logic                pwm_out;
  logic [PWM_BITS-1:0] duty;
  logic                estavel;
  logic                ocupado;

  // Controller side: issues the request, observes lamp status.
  modport master (
    output liga, nivel,
    input  pwm_out, duty, estavel, ocupado
  );

  // Driver side: consumes the request, drives lamp and status.
  modport slave (
    input  liga, nivel,
    output pwm_out, duty, estavel, ocupado
  );

endinterface

// File: rtl/driver_lampada_pwm_gerador_pwm.sv
// Free-running PWM generator: counter 0..2^PWM_BITS-2, pwm_out = (counter < duty).
// Latency: one cycle from counter/duty to pwm_out.
// Backpressure: none; duty changes apply at the next compare, no period alignment.
//
// Ports: clk, rst (sync, active-high), duty (compare level), pwm_out (registered drive).
module gerador_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  // The period is 2^PWM_BITS-1 so that the all-ones duty gives a constant-high output.
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] contador;

  always_ff @(posedge clk) begin
    if (rst) begin
      contador <= '0;
      pwm_out  <= 1'b0;
    end else begin
      contador <= (contador == CNT_MAX) ? '0 : contador + 1'b1;
      pwm_out  <= (contador < duty);
    end
  end

endmodule

// File: rtl/driver_lampada_pwm.sv
// Soft-start/soft-stop lamp driver: ramps duty one LSB every RAMP_STEP_T cycles toward
// liga ? nivel : 0. Latency: state follows liga/nivel on the next edge; duty reaches N
// after N*RAMP_STEP_T edges. Backpressure: none; inputs are level-sampled every cycle.
//
// Ports: clk, rst (sync, active-high), bus (slave modport: liga, nivel in;
//        pwm_out, duty, estavel, ocupado out).
module driver_lampada_pwm
  import lampada_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP_T = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  driver_lampada_pwm_if.slave   bus
);

  localparam int TW = $clog2(RAMP_STEP_T + 1);
  localparam logic [TW-1:0] TMAX = TW'(RAMP_STEP_T - 1);

  estado_lampada_t     estado, estado_prox;
  logic [PWM_BITS-1:0] duty, duty_prox;
  logic [TW-1:0]       timer, timer_prox;
  logic [PWM_BITS-1:0] alvo;
  logic                passo;
  logic                reversao;
  logic                pwm_w;

  always_comb begin
    alvo        = bus.liga ? bus.nivel : '0;
    duty_prox   = duty;
    estado_prox = estado;
    timer_prox  = '0;
    reversao    = 1'b0;

    // A step fires on the last timer count in the direction latched last cycle, even if
    // the target moved this cycle; it is dropped only when duty already sits on target.
    passo = em_rampa(estado) && (timer == TMAX) && (duty != alvo);
    if (passo) begin
      duty_prox = (estado == SUBINDO) ? duty + 1'b1 : duty - 1'b1;
    end

    if (duty_prox < alvo) begin
      estado_prox = SUBINDO;
    end else if (duty_prox > alvo) begin
      estado_prox = DESCENDO;
    end else if (alvo == '0) begin
      estado_prox = REPOUSO;
    end else begin
      estado_prox = ACESA;
    end

    reversao = ((estado == SUBINDO)  && (estado_prox == DESCENDO)) ||
               ((estado == DESCENDO) && (estado_prox == SUBINDO));

    // Timer keeps counting only while staying in the same ramp direction; entering a ramp,
    // reversing, wrapping after a step, or settling all restart it from zero.
    if (em_rampa(estado_prox) && em_rampa(estado) && !reversao && (timer != TMAX)) begin
      timer_prox = timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOUSO;
      duty   <= '0;
      timer  <= '0;
    end else begin
      estado <= estado_prox;
      duty   <= duty_prox;
      timer  <= timer_prox;
    end
  end

  gerador_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .pwm_out (pwm_w)
  );

  assign bus.pwm_out = pwm_w;
  assign bus.duty    = duty;
  assign bus.estavel = !em_rampa(estado);
  assign bus.ocupado = em_rampa(estado);

endmodule

// File: tb/tb_driver_lampada_pwm.sv
// Directed bench for driver_lampada_pwm with PWM_BITS=4, RAMP_STEP_T=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point, so a
// sample taken after tick() reflects the state right after that edge.
module tb_driver_lampada_pwm;
  import lampada_pkg::*;

  localparam int PB = 4;
  localparam int RT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_m = 0;   // reference model of the PWM counter (period 15)
  int highs;

  driver_lampada_pwm_if #(.PWM_BITS(PB)) bus ();

  driver_lampada_pwm #(
    .PWM_BITS    (PB),
    .RAMP_STEP_T (RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cnt_m <= 0;
    else     cnt_m <= (cnt_m == 14) ? 0 : cnt_m + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for the lamp to settle at a given duty.
  task automatic wait_settle(input string tag, input int tgt, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.estavel === 1'b1 && int'(bus.duty) == tgt) break;
      tick();
    end
    chk({tag, "_duty"}, int'(bus.duty), tgt);
    chk({tag, "_estavel"}, int'(bus.estavel), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.liga  = 1'b0;
    bus.nivel = '0;
    tick(2);
    // ---------------- 1: reset and idle, nivel ignored while liga=0
    chk("rst_duty", int'(bus.duty), 0);
    chk("rst_pwm", int'(bus.pwm_out), 0);
    chk("rst_estavel", int'(bus.estavel), 1);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_state", int'(dut.estado), int'(REPOUSO));
    rst = 1'b0;
    bus.nivel = 4'd9;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_duty", int'(bus.duty), 0);
      chk("idle_pwm", int'(bus.pwm_out), 0);
      chk("idle_estavel", int'(bus.estavel), 1);
    end

    // ---------------- 2: full ramp to 15
    bus.liga  = 1'b1;
    bus.nivel = 4'd15;
    tick();                                   // edge k
    chk("up_ocupado_k", int'(bus.ocupado), 1);
    chk("up_timer_k", int'(dut.timer), 0);
    chk("up_duty_k", int'(bus.duty), 0);
    tick(3);                                  // k+3
    chk("up_duty_k3", int'(bus.duty), 0);
    tick();                                   // k+4
    chk("up_duty_k4", int'(bus.duty), 1);
    tick(55);                                 // k+59
    chk("up_duty_k59", int'(bus.duty), 14);
    chk("up_estavel_k59", int'(bus.estavel), 0);
    tick();                                   // k+60
    chk("up_duty_k60", int'(bus.duty), 15);
    chk("up_estavel_k60", int'(bus.estavel), 1);
    chk("up_state_k60", int'(dut.estado), int'(ACESA));
    tick();
    for (int i = 0; i < 30; i++) begin
      chk("full_pwm_high", int'(bus.pwm_out), 1);
      tick();
    end

    // ---------------- 3: steady duty 6
    bus.nivel = 4'd6;
    wait_settle("dn6", 6, 100);
    tick();
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      chk("pwm6_phase", int'(bus.pwm_out), (((cnt_m + 14) % 15) < 6) ? 1 : 0);
      highs += int'(bus.pwm_out);
      tick();
    end
    chk("pwm6_high_count", highs, 6);

    // ---------------- 4: reverse mid-ramp
    bus.liga = 1'b0;
    wait_settle("off4", 0, 100);
    bus.liga  = 1'b1;
    bus.nivel = 4'd10;
    tick();                                   // k
    tick(22);                                 // k+22: duty=5, timer=2
    chk("rev_duty5", int'(bus.duty), 5);
    chk("rev_timer2", int'(dut.timer), 2);
    bus.liga = 1'b0;
    tick();
    chk("rev_state", int'(dut.estado), int'(DESCENDO));
    chk("rev_timer0", int'(dut.timer), 0);
    chk("rev_duty_hold", int'(bus.duty), 5);
    tick(3);
    chk("rev_duty_3", int'(bus.duty), 5);
    tick();
    chk("rev_duty4", int'(bus.duty), 4);
    tick(15);
    chk("rev_duty1", int'(bus.duty), 1);
    chk("rev_ocupado", int'(bus.ocupado), 1);
    tick();
    chk("rev_duty0", int'(bus.duty), 0);
    chk("rev_state_off", int'(dut.estado), int'(REPOUSO));
    chk("rev_estavel", int'(bus.estavel), 1);

    // ---------------- 5: level change while lit
    bus.liga  = 1'b1;
    bus.nivel = 4'd10;
    wait_settle("up10", 10, 100);
    bus.nivel = 4'd7;
    tick();                                   // j+1
    chk("lv_dn_state", int'(dut.estado), int'(DESCENDO));
    tick(3);
    chk("lv_dn_10", int'(bus.duty), 10);
    tick();
    chk("lv_dn_9", int'(bus.duty), 9);
    tick(4);
    chk("lv_dn_8", int'(bus.duty), 8);
    tick(4);
    chk("lv_dn_7", int'(bus.duty), 7);
    chk("lv_dn_estavel", int'(bus.estavel), 1);
    bus.nivel = 4'd10;
    tick();
    chk("lv_up_state", int'(dut.estado), int'(SUBINDO));
    tick(4);
    chk("lv_up_8", int'(bus.duty), 8);
    tick(4);
    chk("lv_up_9", int'(bus.duty), 9);
    tick(4);
    chk("lv_up_10", int'(bus.duty), 10);
    chk("lv_up_estavel", int'(bus.estavel), 1);

    // ---------------- 6: reset mid-ramp
    bus.liga = 1'b0;
    wait_settle("off6", 0, 100);
    bus.liga  = 1'b1;
    bus.nivel = 4'd15;
    tick();
    tick(32);
    chk("mr_duty8", int'(bus.duty), 8);
    chk("mr_ocupado", int'(bus.ocupado), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_duty0", int'(bus.duty), 0);
    chk("mr_pwm0", int'(bus.pwm_out), 0);
    chk("mr_estavel", int'(bus.estavel), 1);
    chk("mr_counter", int'(dut.u_pwm.contador), 0);
    chk("mr_state", int'(dut.estado), int'(REPOUSO));
    tick();
    chk("mr_restart_state", int'(dut.estado), int'(SUBINDO));
    chk("mr_restart_duty", int'(bus.duty), 0);
    tick(4);
    chk("mr_restart_duty1", int'(bus.duty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
